mul_unit_pipe: RTL

//  Parametrised, flushable, pipelined integer multiplier for the exe stage (RV64M MUL/MULH/MULHSU/MULHU/MULW).

---
 rtl/drac_pkg.sv | 18 +
 rtl/mul_partial_array.sv | 34 +++
 rtl/mul_unit_pipe.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/drac_pkg.sv
// Shared execution-unit definitions: multiplier opcodes and latency helper.
package drac_pkg;

  typedef enum logic [1:0] {
    MUL_OP    = 2'b00,
    MULH_OP   = 2'b01,
    MULHSU_OP = 2'b10,
    MULHU_OP  = 2'b11
  } mul_op_t;

  localparam int MUL_BASE_LAT = 2;
  localparam int WORD_W       = 32;

  function automatic int mul_lat(input int extra_pipe);
    return MUL_BASE_LAT + extra_pipe;
  endfunction

endpackage

// File: rtl/mul_partial_array.sv
// Registered partial-product generator: one |a| * chunk(|b|) product per chunk.
module mul_partial_array #(
  parameter  int XLEN    = 64,
  parameter  int CHUNK_W = 32,
  localparam int NCHUNK  = XLEN / CHUNK_W,
  localparam int PP_W    = XLEN + CHUNK_W
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   load,
  input  logic [XLEN-1:0]        mag_a,
  input  logic [XLEN-1:0]        mag_b,
  output logic [NCHUNK*PP_W-1:0] pp
);

  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
    logic [PP_W-1:0] prod_next;
    logic [PP_W-1:0] prod_reg;

    assign prod_next = {{CHUNK_W{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b[gi*CHUNK_W +: CHUNK_W]};

    // Idle stages hold zero so waveforms stay free of stale operands.
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        prod_reg <= '0;
      end else begin
        prod_reg <= load ? prod_next : '0;
      end
    end

    assign pp[gi*PP_W +: PP_W] = prod_reg;
  end

endmodule

// File: rtl/mul_unit_pipe.sv
// Pipelined RV64M multiplier: operand conditioning, partial products, optional
// retiming, early word path with a retire-collision guard, final reduce/negate.
module mul_unit_pipe
  import drac_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int CHUNK_W    = 32,
  parameter int EXTRA_PIPE = 0,
  parameter int W_EARLY    = 1,
  parameter int TAG_W      = 48
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [1:0]       op_i,
  input  logic             word_i,
  input  logic [XLEN-1:0]  src1_i,
  input  logic [XLEN-1:0]  src2_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int NCHUNK   = XLEN / CHUNK_W;
  localparam int PP_W     = XLEN + CHUNK_W;
  localparam int PP_FLAT  = NCHUNK * PP_W;
  localparam int LAT      = mul_lat(EXTRA_PIPE);
  localparam int NSTG     = EXTRA_PIPE + 1;
  localparam int LAST     = NSTG - 1;
  localparam bit EARLY_EN = (W_EARLY != 0);

  mul_op_t         op_in;
  logic            word_in;
  logic            accept;
  logic            sgn1;
  logic            sgn2;
  logic [XLEN-1:0] opnd1;
  logic [XLEN-1:0] opnd2;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;

  assign op_in   = mul_op_t'(op_i);
  assign word_in = word_i & (op_in == MUL_OP);
  assign accept  = valid_i & ready_o & ~flush_i;

  // Signed sources become magnitudes; MIN_INT stays 2^(XLEN-1) read unsigned.
  always_comb begin
    opnd1 = src1_i;
    opnd2 = src2_i;
    if (word_in) begin
      opnd1 = {XLEN{src1_i[WORD_W-1]}};
      opnd1[WORD_W-1:0] = src1_i[WORD_W-1:0];
      opnd2 = {XLEN{src2_i[WORD_W-1]}};
      opnd2[WORD_W-1:0] = src2_i[WORD_W-1:0];
    end
    sgn1 = (op_in != MULHU_OP) & opnd1[XLEN-1];
    sgn2 = ((op_in == MUL_OP) | (op_in == MULH_OP)) & opnd2[XLEN-1];
    mag1 = sgn1 ? -opnd1 : opnd1;
    mag2 = sgn2 ? -opnd2 : opnd2;
  end

  logic             s1_valid_reg;
  logic             s1_word_reg;
  logic             s1_neg_reg;
  mul_op_t          s1_op_reg;
  logic [XLEN-1:0]  s1_mag1_reg;
  logic [XLEN-1:0]  s1_mag2_reg;
  logic [TAG_W-1:0] s1_tag_reg;
  logic             s1_early;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_valid_reg <= 1'b0;
      s1_word_reg  <= 1'b0;
      s1_neg_reg   <= 1'b0;
      s1_op_reg    <= MUL_OP;
      s1_mag1_reg  <= '0;
      s1_mag2_reg  <= '0;
      s1_tag_reg   <= '0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
      s1_word_reg  <= word_in;
      s1_neg_reg   <= sgn1 ^ sgn2;
      s1_op_reg    <= op_in;
      s1_mag1_reg  <= mag1;
      s1_mag2_reg  <= mag2;
      s1_tag_reg   <= tag_i;
    end else begin
      s1_valid_reg <= 1'b0;
      s1_word_reg  <= 1'b0;
      s1_neg_reg   <= 1'b0;
      s1_op_reg    <= MUL_OP;
      s1_mag1_reg  <= '0;
      s1_mag2_reg  <= '0;
      s1_tag_reg   <= '0;
    end
  end

  assign s1_early = EARLY_EN & s1_word_reg;

  logic               s2_load;
  logic [PP_FLAT-1:0] pp_s2;

  assign s2_load = s1_valid_reg & ~s1_early & ~flush_i;

  mul_partial_array #(
    .XLEN    (XLEN),
    .CHUNK_W (CHUNK_W)
  ) u_partial (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .load   (s2_load),
    .mag_a  (s1_mag1_reg),
    .mag_b  (s1_mag2_reg),
    .pp     (pp_s2)
  );

  logic               v_chain  [NSTG];
  logic               n_chain  [NSTG];
  logic               w_chain  [NSTG];
  mul_op_t            o_chain  [NSTG];
  logic [TAG_W-1:0]   t_chain  [NSTG];
  logic [PP_FLAT-1:0] pp_chain [NSTG];

  // Stage 0 is S2 (products live in u_partial); later stages are plain copies.
  for (genvar gi = 0; gi < NSTG; gi++) begin : g_stg
    logic             in_valid;
    logic             in_neg;
    logic             in_word;
    mul_op_t          in_op;
    logic [TAG_W-1:0] in_tag;
    logic             load;
    logic             valid_reg;
    logic             neg_reg;
    logic             word_reg;
    mul_op_t          op_reg;
    logic [TAG_W-1:0] tag_reg;

    if (gi == 0) begin : g_from_s1
      assign in_valid    = s1_valid_reg & ~s1_early;
      assign in_neg      = s1_neg_reg;
      assign in_word     = s1_word_reg;
      assign in_op       = s1_op_reg;
      assign in_tag      = s1_tag_reg;
      assign pp_chain[0] = pp_s2;
    end else begin : g_from_prev
      logic [PP_FLAT-1:0] pp_reg;

      assign in_valid = v_chain[gi-1];
      assign in_neg   = n_chain[gi-1];
      assign in_word  = w_chain[gi-1];
      assign in_op    = o_chain[gi-1];
      assign in_tag   = t_chain[gi-1];

      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          pp_reg <= '0;
        end else begin
          pp_reg <= load ? pp_chain[gi-1] : '0;
        end
      end

      assign pp_chain[gi] = pp_reg;
    end

    assign load = in_valid & ~flush_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        valid_reg <= 1'b0;
        neg_reg   <= 1'b0;
        word_reg  <= 1'b0;
        op_reg    <= MUL_OP;
        tag_reg   <= '0;
      end else begin
        valid_reg <= load;
        neg_reg   <= load & in_neg;
        word_reg  <= load & in_word;
        op_reg    <= load ? in_op : MUL_OP;
        tag_reg   <= load ? in_tag : '0;
      end
    end

    assign v_chain[gi] = valid_reg;
    assign n_chain[gi] = neg_reg;
    assign w_chain[gi] = word_reg;
    assign o_chain[gi] = op_reg;
    assign t_chain[gi] = tag_reg;
  end

  logic [2*XLEN-1:0] ext;
  logic [2*XLEN-1:0] sum;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   full_res;

  always_comb begin
    ext = '0;
    sum = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      ext = '0;
      ext[PP_W-1:0] = pp_chain[LAST][k*PP_W +: PP_W];
      sum = sum + (ext << (k * CHUNK_W));
    end
    prod     = n_chain[LAST] ? -sum : sum;
    full_res = (o_chain[LAST] == MUL_OP) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    if (w_chain[LAST]) begin
      full_res = {XLEN{prod[WORD_W-1]}};
      full_res[WORD_W-1:0] = prod[WORD_W-1:0];
    end
  end

  // Early word path: only the low word of the product is needed.
  logic [WORD_W-1:0] early_lo;
  logic [XLEN-1:0]   early_res;
  logic              early_hit;

  always_comb begin
    early_lo = s1_mag1_reg[WORD_W-1:0] * s1_mag2_reg[WORD_W-1:0];
    if (s1_neg_reg) begin
      early_lo = -early_lo;
    end
    early_res = {XLEN{early_lo[WORD_W-1]}};
    early_res[WORD_W-1:0] = early_lo;
  end

  assign early_hit = s1_valid_reg & s1_early;
  assign valid_o   = early_hit | v_chain[LAST];
  assign result_o  = early_hit ? early_res : full_res;
  assign tag_o     = early_hit ? s1_tag_reg : t_chain[LAST];

  // A word op accepted now would retire alongside the full op one stage from the end.
  logic guard_busy;

  if (!EARLY_EN || LAT <= 1) begin : g_no_guard
    assign guard_busy = 1'b0;
  end else if (EXTRA_PIPE == 0) begin : g_guard_s1
    assign guard_busy = s1_valid_reg & ~s1_early;
  end else begin : g_guard_stg
    assign guard_busy = v_chain[EXTRA_PIPE-1];
  end

  assign ready_o = ~(valid_i & word_in & guard_busy);

endmodule
